// File: rtl/ulpi_reg_arbiter.sv
// ---------------------------------------------------------------------------
// ulpi_reg_arbiter
//
// Lets N_REQ on-chip requesters share the single ULPI PHY register-access
// path. Requesters are, for example, the init sequencer, the USB device core
// and a debug bridge. Only one register access is in flight at a time.
//
//   - Requesters are granted in round-robin order. A grant is only given
//     while the link is ready.
//   - The latched command is handed to the link engine with a valid/ready
//     handshake.
//   - If the link aborts the command (PHY took DIR for an RX CMD), the same
//     command is re-issued, up to MAX_RETRY times.
//   - Every attempt is bounded by TIMEOUT_CYCLES.
//   - The result goes back to the granted requester as a one-cycle
//     o_ack or o_err pulse, together with o_rdata.
//
// Ports
//   i_clk, i_rst      60 MHz ULPI clock, synchronous active-high reset
//   i_link_ready      PHY strap/reset sequence done; gates new grants only
//   i_req[k]          level request from requester k, held until ack/err
//   i_req_we[k]       1 = register write, 0 = register read
//   i_req_addr        6-bit address per requester, k at [6k+5:6k]
//   i_req_wdata       8-bit write data per requester, k at [8k+7:8k]
//   o_ack / o_err     one-cycle completion pulses, one bit per requester
//   o_rdata           read data while o_ack is high on a read, else 0
//   o_cmd_*           command to the ULPI link engine (valid/ready)
//   i_cmd_done        one-cycle pulse: command finished on the bus
//   i_cmd_abort       one-cycle pulse: command aborted by DIR
//   i_cmd_rdata       read data, valid with i_cmd_done
//   o_busy            high whenever an access is in progress
// ---------------------------------------------------------------------------
module ulpi_reg_arbiter #(
   parameter int N_REQ          = 4,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_link_ready,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ-1:0]   i_req_we,
   input  logic [6*N_REQ-1:0] i_req_addr,
   input  logic [8*N_REQ-1:0] i_req_wdata,
   output logic [N_REQ-1:0]   o_ack,
   output logic [N_REQ-1:0]   o_err,
   output logic [7:0]         o_rdata,
   output logic               o_cmd_valid,
   input  logic               i_cmd_ready,
   output logic               o_cmd_we,
   output logic [5:0]         o_cmd_addr,
   output logic [7:0]         o_cmd_wdata,
   input  logic               i_cmd_done,
   input  logic               i_cmd_abort,
   input  logic [7:0]         i_cmd_rdata,
   output logic               o_busy
);

   localparam int PTR_W   = $clog2(N_REQ);
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   // A zero-retry build still needs a 1-bit counter.
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);
   localparam logic [PTR_W:0]     N_REQ_EXT  = (PTR_W + 1)'(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t               state_reg;
   logic [PTR_W-1:0]     rr_ptr_reg;
   logic [PTR_W-1:0]     idx_reg;
   logic [RETRY_W-1:0]   retry_cnt_reg;
   logic [TIMER_W-1:0]   timer_reg;

   // Per-requester views of the flattened address/data buses.
   logic [5:0] req_addr_arr  [N_REQ];
   logic [7:0] req_wdata_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_addr_arr[gi]  = i_req_addr[6*gi +: 6];
         assign req_wdata_arr[gi] = i_req_wdata[8*gi +: 8];
      end
   endgenerate

   // Round-robin pick.
   // Scan rr_ptr, rr_ptr+1, ... and wrap modulo N_REQ, so that N_REQ
   // values that are not a power of two also work.
   logic             grant_found;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W:0]   cand_ext;
   logic [PTR_W-1:0] cand_idx;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_ptr_reg;
      cand_ext    = '0;
      cand_idx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_ext = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(i);
         if (cand_ext >= N_REQ_EXT) begin
            cand_ext = cand_ext - N_REQ_EXT;
         end
         cand_idx = cand_ext[PTR_W-1:0];
         if (!grant_found && i_req[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   logic [N_REQ-1:0] idx_onehot;
   assign idx_onehot = N_REQ'(1) << idx_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= ST_IDLE;
         rr_ptr_reg    <= '0;
         idx_reg       <= '0;
         retry_cnt_reg <= '0;
         timer_reg     <= '0;
         o_ack         <= '0;
         o_err         <= '0;
         o_rdata       <= '0;
         o_cmd_valid   <= 1'b0;
         o_cmd_we      <= 1'b0;
         o_cmd_addr    <= '0;
         o_cmd_wdata   <= '0;
         o_busy        <= 1'b0;
      end else begin
         // Completion outputs are single-cycle pulses.
         o_ack <= '0;
         o_err <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (i_link_ready && grant_found) begin
                  idx_reg       <= grant_idx;
                  o_cmd_we      <= i_req_we[grant_idx];
                  o_cmd_addr    <= req_addr_arr[grant_idx];
                  o_cmd_wdata   <= req_wdata_arr[grant_idx];
                  retry_cnt_reg <= '0;
                  o_cmd_valid   <= 1'b1;
                  o_busy        <= 1'b1;
                  state_reg     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (i_cmd_ready) begin
                  o_cmd_valid <= 1'b0;
                  timer_reg   <= '0;
                  state_reg   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               timer_reg <= timer_reg + TIMER_W'(1);
               // A done pulse wins over an abort or a timeout in the same cycle.
               if (i_cmd_done) begin
                  o_ack     <= idx_onehot;
                  o_rdata   <= o_cmd_we ? 8'h00 : i_cmd_rdata;
                  state_reg <= ST_RESP;
               end else if (i_cmd_abort) begin
                  if (retry_cnt_reg < RETRY_MAX) begin
                     // The command fields are still latched, so the
                     // re-issue is the same command.
                     retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
                     o_cmd_valid   <= 1'b1;
                     state_reg     <= ST_ISSUE;
                  end else begin
                     o_err     <= idx_onehot;
                     state_reg <= ST_RESP;
                  end
               end else if (timer_reg == TIMER_LAST) begin
                  o_err     <= idx_onehot;
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               o_rdata    <= '0;
               o_busy     <= 1'b0;
               rr_ptr_reg <= (idx_reg == PTR_LAST) ? '0 : idx_reg + PTR_W'(1);
               state_reg  <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_arbiter
//
// Self-checking bench for ulpi_reg_arbiter (N_REQ=4, MAX_RETRY=3,
// TIMEOUT_CYCLES=16).
//
// A small link-engine model (link_serve) plays the ULPI side of each access
// and records what it saw. Each test task compares those observations with
// values derived from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_arbiter;

   localparam int N    = 4;
   localparam int MAXR = 3;
   localparam int TMO  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           link_ready;
   logic [N-1:0]   req;
   logic [N-1:0]   req_we;
   logic [6*N-1:0] req_addr;
   logic [8*N-1:0] req_wdata;
   logic [N-1:0]   ack;
   logic [N-1:0]   err;
   logic [7:0]     rdata;
   logic           cmd_valid;
   logic           cmd_ready;
   logic           cmd_we;
   logic [5:0]     cmd_addr;
   logic [7:0]     cmd_wdata;
   logic           cmd_done;
   logic           cmd_abort;
   logic [7:0]     cmd_rdata;
   logic           busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ulpi_reg_arbiter #(
      .N_REQ          (N),
      .MAX_RETRY      (MAXR),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_link_ready (link_ready),
      .i_req        (req),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_ack        (ack),
      .o_err        (err),
      .o_rdata      (rdata),
      .o_cmd_valid  (cmd_valid),
      .i_cmd_ready  (cmd_ready),
      .o_cmd_we     (cmd_we),
      .o_cmd_addr   (cmd_addr),
      .o_cmd_wdata  (cmd_wdata),
      .i_cmd_done   (cmd_done),
      .i_cmd_abort  (cmd_abort),
      .i_cmd_rdata  (cmd_rdata),
      .o_busy       (busy)
   );

   // Advance one clock. Inputs are driven and outputs are sampled 1 time
   // unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic we, input logic [5:0] a, input logic [7:0] d);
      req[k]             = 1'b1;
      req_we[k]          = we;
      req_addr[6*k +: 6] = a;
      req_wdata[8*k +: 8] = d;
   endtask

   task automatic go_idle();
      req = '0;
      repeat (3) tick();
   endtask

   // Link-engine model.
   //
   // For each attempt it:
   //   1. waits for o_cmd_valid,
   //   2. delays ready by rdy_dly cycles, then handshakes,
   //   3. aborts the first n_abort attempts; after that it reports done
   //      (if give_done) or stays silent.
   //      Each response is given done_dly cycles after the handshake.
   //
   // Returned observations:
   //   - hs_cnt: number of handshakes
   //   - c_we, c_addr, c_wdata: command fields at the last handshake
   //   - ack_seen, err_seen, rdata_seen: the completion pulse
   //   - lat: edges from the last handshake to that pulse
   //   - drop_bad: valid stayed high after a handshake
   //   - hung: a wait ran out of budget
   task automatic link_serve(
      input  int           n_abort,
      input  bit           give_done,
      input  logic [7:0]   rd,
      input  int           rdy_dly,
      input  int           done_dly,
      output int           hs_cnt,
      output logic         c_we,
      output logic [5:0]   c_addr,
      output logic [7:0]   c_wdata,
      output logic [N-1:0] ack_seen,
      output logic [N-1:0] err_seen,
      output logic [7:0]   rdata_seen,
      output int           lat,
      output bit           drop_bad,
      output bit           hung
   );
      int attempt;
      int n;
      bit finished;
      bit reissued;
      hs_cnt = 0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      ack_seen = '0; err_seen = '0; rdata_seen = '0; lat = 0;
      drop_bad = 1'b0; hung = 1'b0; attempt = 0; finished = 1'b0;
      while (!finished && !hung) begin
         for (int w = 0; w < 30 && cmd_valid !== 1'b1; w++) tick();
         if (cmd_valid !== 1'b1) begin
            hung = 1'b1;
         end else begin
            repeat (rdy_dly) tick();
            c_we = cmd_we; c_addr = cmd_addr; c_wdata = cmd_wdata;
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            hs_cnt++;
            if (cmd_valid !== 1'b0) drop_bad = 1'b1;
            n = 0;
            if (attempt < n_abort || give_done) begin
               repeat (done_dly) begin
                  tick();
                  n++;
               end
               if (attempt < n_abort) begin
                  cmd_abort = 1'b1;
               end else begin
                  cmd_done  = 1'b1;
                  cmd_rdata = rd;
               end
               tick();
               n++;
               cmd_abort = 1'b0;
               cmd_done  = 1'b0;
               cmd_rdata = 8'($urandom);
            end
            attempt++;
            reissued = 1'b0;
            for (int w = 0; w < 40 && !finished && !reissued; w++) begin
               if ((ack | err) != '0) begin
                  ack_seen = ack; err_seen = err; rdata_seen = rdata; lat = n;
                  finished = 1'b1;
               end else if (cmd_valid === 1'b1) begin
                  reissued = 1'b1;
               end else begin
                  tick();
                  n++;
               end
            end
            if (!finished && !reissued) hung = 1'b1;
         end
      end
      $display("txn: hs=%0d addr=%h we=%b wdata=%h ack=%b err=%b rdata=%h lat=%0d hung=%0d",
               hs_cnt, c_addr, c_we, c_wdata, ack_seen, err_seen, rdata_seen, lat, hung);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      total++;
      if ({ack, err, rdata, cmd_valid, cmd_we, cmd_addr, cmd_wdata, busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: ack=%b err=%b rdata=%h valid=%b busy=%b required all 0", ack, err, rdata, cmd_valid, busy);
      end
      rst = 1'b0;
      tick();
      total++;
      if ({cmd_valid, busy} !== 2'b00) begin
         bad++;
         $display("FAIL reset_idle: valid=%b busy=%b required 0 0", cmd_valid, busy);
      end
   endtask

   task automatic test_write();
      int hs, lat; bit drop_bad, hung;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s; logic [N-1:0] a_s, e_s;
      set_req(0, 1'b1, 6'h04, 8'h45);
      tick();
      total++;
      if (cmd_valid !== 1'b1) begin
         bad++;
         $display("FAIL write_latency: valid=%b required 1", cmd_valid);
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL write_busy: busy=%b required 1", busy);
      end
      link_serve(0, 1'b1, 8'h3C, 0, 2, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || hs !== 1 || drop_bad) begin
         bad++;
         $display("FAIL write_handshake: hung=%0d hs=%0d drop_bad=%0d required 0 1 0", hung, hs, drop_bad);
      end
      total++;
      if ({c_we, c_addr, c_wd} !== {1'b1, 6'h04, 8'h45}) begin
         bad++;
         $display("FAIL write_fields: we=%b addr=%h wdata=%h required 1 04 45", c_we, c_addr, c_wd);
      end
      total++;
      if (a_s !== 4'b0001 || e_s !== 4'b0000 || rd_s !== 8'h00) begin
         bad++;
         $display("FAIL write_resp: ack=%b err=%b rdata=%h required 0001 0000 00", a_s, e_s, rd_s);
      end
      req = '0;
      tick();
      total++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL write_pulse: ack=%b busy=%b required 0000 0", ack, busy);
      end
      go_idle();
   endtask

   task automatic test_read();
      int hs, lat; bit drop_bad, hung;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s; logic [N-1:0] a_s, e_s;
      set_req(2, 1'b0, 6'h16, 8'h00);
      link_serve(0, 1'b1, 8'hA5, 1, 0, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || a_s !== 4'b0100 || e_s !== 4'b0000 || rd_s !== 8'hA5) begin
         bad++;
         $display("FAIL read_resp: hung=%0d ack=%b err=%b rdata=%h required 0 0100 0000 a5", hung, a_s, e_s, rd_s);
      end
      total++;
      if ({c_we, c_addr} !== {1'b0, 6'h16}) begin
         bad++;
         $display("FAIL read_fields: we=%b addr=%h required 0 16", c_we, c_addr);
      end
      req = '0;
      tick();
      total++;
      if (rdata !== 8'h00) begin
         bad++;
         $display("FAIL read_rdata_clear: rdata=%h required 00", rdata);
      end
      go_idle();
   endtask

   task automatic test_round_robin();
      int hs, lat; bit drop_bad, hung;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s; logic [N-1:0] a_s, e_s, exp_a;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < N; k++) set_req(k, 1'b1, 6'(8 + k), 8'(16 + k));
      for (int i = 0; i < 6; i++) begin
         link_serve(0, 1'b1, 8'h00, 0, 0, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
         exp_a = '0;
         exp_a[i % N] = 1'b1;
         total++;
         if (hung || a_s !== exp_a || c_addr !== 6'(8 + (i % N))) begin
            bad++;
            $display("FAIL rr_order[%0d]: hung=%0d ack=%b addr=%h required ack=%b addr=%h", i, hung, a_s, c_addr, exp_a, 6'(8 + (i % N)));
         end
      end
      go_idle();
   endtask

   task automatic test_retry();
      int hs, lat; bit drop_bad, hung;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s; logic [N-1:0] a_s, e_s;
      set_req(3, 1'b1, 6'h2A, 8'h5A);
      link_serve(2, 1'b1, 8'h00, 0, 1, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || hs !== 3 || a_s !== 4'b1000 || e_s !== 4'b0000) begin
         bad++;
         $display("FAIL retry_ok: hung=%0d hs=%0d ack=%b err=%b required 0 3 1000 0000", hung, hs, a_s, e_s);
      end
      total++;
      if ({c_we, c_addr, c_wd} !== {1'b1, 6'h2A, 8'h5A}) begin
         bad++;
         $display("FAIL retry_fields: we=%b addr=%h wdata=%h required 1 2a 5a", c_we, c_addr, c_wd);
      end
      go_idle();
      set_req(1, 1'b0, 6'h0A, 8'h00);
      link_serve(4, 1'b1, 8'h77, 0, 0, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || hs !== MAXR + 1 || a_s !== 4'b0000 || e_s !== 4'b0010) begin
         bad++;
         $display("FAIL retry_exhaust: hung=%0d hs=%0d ack=%b err=%b required 0 4 0000 0010", hung, hs, a_s, e_s);
      end
      go_idle();
   endtask

   task automatic test_timeout();
      int hs, lat; bit drop_bad, hung;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s; logic [N-1:0] a_s, e_s;
      set_req(0, 1'b0, 6'h01, 8'h00);
      link_serve(0, 1'b0, 8'h00, 0, 0, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || e_s !== 4'b0001 || a_s !== 4'b0000 || lat !== TMO) begin
         bad++;
         $display("FAIL timeout_err: hung=%0d err=%b ack=%b lat=%0d required 0 0001 0000 %0d", hung, e_s, a_s, lat, TMO);
      end
      go_idle();
      set_req(0, 1'b0, 6'h01, 8'h00);
      link_serve(0, 1'b1, 8'h9C, 0, TMO - 1, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || a_s !== 4'b0001 || e_s !== 4'b0000 || rd_s !== 8'h9C || lat !== TMO) begin
         bad++;
         $display("FAIL timeout_done_wins: hung=%0d ack=%b err=%b rdata=%h lat=%0d required 0 0001 0000 9c %0d", hung, a_s, e_s, rd_s, lat, TMO);
      end
      go_idle();
   endtask

   task automatic test_gating();
      int hs, lat; bit drop_bad, hung, seen;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s; logic [N-1:0] a_s, e_s;
      link_ready = 1'b0;
      set_req(1, 1'b1, 6'h05, 8'h11);
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (cmd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL gate_block: valid/busy seen=%0d required 0", seen);
      end
      link_ready = 1'b1;
      link_serve(0, 1'b1, 8'h00, 0, 0, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || a_s !== 4'b0010) begin
         bad++;
         $display("FAIL gate_release: hung=%0d ack=%b required 0 0010", hung, a_s);
      end
      go_idle();
      // Start an access on requester 2 and reset while it is in WAIT.
      set_req(2, 1'b1, 6'h11, 8'h22);
      tick();
      total++;
      if (cmd_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_issue: valid=%b required 1", cmd_valid);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      repeat (2) tick();
      req = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({busy, cmd_valid, ack, err} !== '0) begin
         bad++;
         $display("FAIL rst_mid: busy=%b valid=%b ack=%b err=%b required all 0", busy, cmd_valid, ack, err);
      end
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         if ((ack | err) != '0 || cmd_valid !== 1'b0) seen = 1'b1;
         tick();
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL rst_silent: ack/err/valid seen=%0d required 0", seen);
      end
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 6'(32 + k), 8'h00);
      link_serve(0, 1'b1, 8'h44, 0, 0, hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
      total++;
      if (hung || a_s !== 4'b0001 || c_addr !== 6'h20) begin
         bad++;
         $display("FAIL rst_ptr: hung=%0d ack=%b addr=%h required 0 0001 20", hung, a_s, c_addr);
      end
      go_idle();
   endtask

   task automatic test_random();
      int hs, lat, ptr, exp_idx, n_abort, kind, exp_hs; bit drop_bad, hung, give_done, exp_ok;
      logic c_we; logic [5:0] c_addr; logic [7:0] c_wd, rd_s, rd, exp_rd; logic [N-1:0] a_s, e_s, exp_a, exp_e, mask;
      logic       m_we   [N];
      logic [5:0] m_addr [N];
      logic [7:0] m_wd   [N];
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ptr = 0;
      for (int t = 0; t < 30; t++) begin
         mask = 4'($urandom_range(1, 15));
         req = '0;
         for (int k = 0; k < N; k++) begin
            m_we[k] = 1'($urandom); m_addr[k] = 6'($urandom); m_wd[k] = 8'($urandom);
            req_we[k] = m_we[k]; req_addr[6*k +: 6] = m_addr[k]; req_wdata[8*k +: 8] = m_wd[k];
         end
         req = mask;
         kind = $urandom_range(0, 9);
         if (kind < 6) begin
            n_abort = $urandom_range(0, MAXR); give_done = 1'b1;
         end else if (kind < 8) begin
            n_abort = MAXR + 1; give_done = 1'($urandom);
         end else begin
            n_abort = $urandom_range(0, 2); give_done = 1'b0;
         end
         rd = 8'($urandom);
         // Reference: first requesting index at or after the pointer, mod N.
         exp_idx = -1;
         for (int j = 0; j < N; j++) if (exp_idx < 0 && mask[(ptr + j) % N]) exp_idx = (ptr + j) % N;
         exp_ok = (n_abort <= MAXR) && give_done;
         exp_hs = (n_abort > MAXR) ? MAXR + 1 : n_abort + 1;
         exp_a = '0; exp_e = '0;
         if (exp_ok) exp_a[exp_idx] = 1'b1; else exp_e[exp_idx] = 1'b1;
         exp_rd = (exp_ok && !m_we[exp_idx]) ? rd : 8'h00;
         ptr = (exp_idx + 1) % N;
         link_serve(n_abort, give_done, rd, $urandom_range(0, 3), $urandom_range(0, 4),
                    hs, c_we, c_addr, c_wd, a_s, e_s, rd_s, lat, drop_bad, hung);
         total++;
         if (hung || a_s !== exp_a || e_s !== exp_e || rd_s !== exp_rd || hs !== exp_hs) begin
            bad++;
            $display("FAIL rand_resp[%0d]: hung=%0d ack=%b err=%b rdata=%h hs=%0d required ack=%b err=%b rdata=%h hs=%0d",
                     t, hung, a_s, e_s, rd_s, hs, exp_a, exp_e, exp_rd, exp_hs);
         end
         total++;
         if ({c_we, c_addr, c_wd} !== {m_we[exp_idx], m_addr[exp_idx], m_wd[exp_idx]}) begin
            bad++;
            $display("FAIL rand_fields[%0d]: we=%b addr=%h wdata=%h required %b %h %h",
                     t, c_we, c_addr, c_wd, m_we[exp_idx], m_addr[exp_idx], m_wd[exp_idx]);
         end
         if (hung) begin
            req = '0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            ptr = 0;
         end
      end
      go_idle();
   endtask

   initial begin
      rst        = 1'b1;
      link_ready = 1'b1;
      req        = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      cmd_ready  = 1'b0;
      cmd_done   = 1'b0;
      cmd_abort  = 1'b0;
      cmd_rdata  = '0;
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_retry();
      test_timeout();
      test_gating();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
